pw_capture_arbiter: RTL and testbench
=====================================

# pw_capture_arbiter

Multi-channel pulse-width capture controller for the logic analyzer. It sequences NCH pulse-width measurement lanes through an arm / run / drain session and arbitrates their completed results round-robin onto a single valid/ready result stream. It sits between the probe inputs and the readout path, and replaces per-channel free-running measurement with a controlled, lossless-or-flagged capture.

## Interface
- NCH, 4: number of measured input channels (2..8)
- WIDTH, 8: width counter / result width in bits
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  pulse; starts a session when IDLE, ignored otherwise
- oneshot  in  1  sampled with arm; 1 = one result per channel then stop
- stop  in  1  pulse; ends a continuous session (RUN -> DRAIN)
- in_data  in  NCH  probe inputs, one bit per channel, already synchronous to clk
- out_valid  out  1  result word available
- out_ready  in  1  consumer accepts result when high with out_valid
- out_data  out  WIDTH  measured high time in clk cycles
- out_ch  out  $clog2(NCH)  channel index of out_data
- out_ovf  out  1  result follows at least one dropped result (see Configuration)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on arm; latch oneshot into mode register; clear all lane done flags.
  - RUN -> DRAIN on stop (continuous mode), or when oneshot mode and every lane is done.
  - DRAIN -> IDLE when no lane pending and output slot empty (or emptying this cycle).
  - arm in RUN/DRAIN ignored; stop outside RUN ignored; arm and stop same cycle in IDLE: arm wins.
- Lane (per channel), RUN only:
  - Tracking begins only on a rising edge seen while in RUN; an input already high at arm is ignored until it falls and rises again.
  - Each edge with in_data=1 while tracking: count += 1, saturating at 2^WIDTH-1.
  - First edge with in_data=0 while tracking: result <= count, pending <= 1, count <= 0, tracking <= 0, done <= 1.
  - oneshot: a done lane starts no further measurements.
  - Leaving RUN abandons any in-progress measurement (count cleared, no result).
- Arbiter: round-robin over pending lanes, pointer reset to 0; after granting g, pointer = (g+1) mod NCH.
  - Output slot loads when empty or being accepted (out_valid && out_ready); granted lane's pending cleared on the same edge.
  - New completion on a lane whose pending is set and not granted that edge: new result dropped, older one kept, lane ovf flag set.
  - Completion on the same edge the lane is granted: new result captured, no drop.
- Reset: state IDLE, all counters/flags/pointer 0; out_valid, out_data, out_ch, out_ovf, busy = 0. Reset mid-session discards everything.

## Timing
- Pulse high for P consecutive sampled edges yields out_data = min(P, 2^WIDTH-1).
- Falling edge sampled at edge k: pending after k; out_valid after k+1 if slot free (latency 2 edges from falling sample).
- out_valid, out_data, out_ch, out_ovf held stable until accepted; one transfer per cycle at most.
- busy rises the edge after arm; falls the edge after the DRAIN exit condition.

## Configuration
- PW_ARB_OVF_EN defined: per-lane sticky ovf flag; out_ovf = that lane's flag when its result loads into the slot, flag cleared on that load; ovf flags cleared at arm.
- Undefined: no ovf storage; out_ovf constant 0; drop behaviour unchanged.

## Structure
- Package pw_arb_pkg: FSM state enum (IDLE, RUN, DRAIN), CHW = $clog2(NCH) helper, saturation max constant.
- Sub-module pw_channel: one lane (edge detect, saturating counter, pending result slot, done and ovf flags); top instantiates NCH copies plus FSM and arbiter.

## Test plan
- arm, oneshot=0; ch0 high 5 edges -> one word out_data=5, out_ch=0, out_ovf=0, 2 edges after falling sample.
- ch1 high 300 edges, WIDTH=8 -> out_data=255.
- ch0..ch3 fall on same edge, out_ready=1 -> words for ch0,1,2,3 on four consecutive cycles in that order.
- out_ready=0, ch2 completes pulses of 3 then 7 -> single word out_data=3 held; with PW_ARB_OVF_EN out_ovf=1, without 0.
- oneshot=1, ch0 high at arm then pulses 4 and 6 -> ch0 word 6 is not produced; first valid pulse only; busy drops after all lanes delivered.
- rst asserted mid-pulse in RUN -> next edge all outputs 0, state IDLE, no stale word after re-arm.

Source files
------------

// File: rtl/pw_capture_arbiter_pkg.sv
// pw_arb_pkg: shared FSM state type and sizing helpers for pw_capture_arbiter.
// Contents:
//   state_t  - session FSM states IDLE / RUN / DRAIN
//   chw()    - channel-index width for a given channel count
//   sat_max()- largest value a WIDTH-bit width counter can hold
package pw_arb_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   function automatic int chw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic longint unsigned sat_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction
endpackage

// File: rtl/pw_capture_arbiter_if.sv
// pw_capture_arbiter_if: valid/ready result stream carrying one measured pulse width.
// Signals:
//   out_valid - result word available (producer)
//   out_ready - consumer accepts the word when high with out_valid
//   out_data  - measured high time in clk cycles
//   out_ch    - channel index of out_data
//   out_ovf   - word follows at least one dropped result on its channel
// Modports: master = producer (capture arbiter), slave = consumer (readout).
interface pw_capture_arbiter_if
   import pw_arb_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int WIDTH = 8
);
   logic             out_valid;
   logic             out_ready;
   logic             out_ovf;
   logic [WIDTH-1:0] out_data;
   logic [chw(NCH)-1:0] out_ch;
   modport master(output out_valid, out_data, out_ch, out_ovf, input out_ready);
   modport slave(input out_valid, out_data, out_ch, out_ovf, output out_ready);
endinterface

// File: rtl/pw_capture_arbiter_channel.sv
// pw_channel: one pulse-width measurement lane of pw_capture_arbiter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   run       - session is in RUN; measurements only progress here
//   start     - session is being armed this cycle; clears done/ovf
//   oneshot   - session mode; a done lane starts no further measurement
//   in_bit    - probe input, already synchronous to clk
//   grant     - arbiter takes this lane's pending result this edge
//   pending   - a completed result is waiting for the arbiter
//   result    - the waiting result (saturated high time)
//   done      - lane has completed at least one measurement this session
//   ovf       - sticky dropped-result flag (only with PW_ARB_OVF_EN)
// Optional feature macro: PW_ARB_OVF_EN (per-lane ovf storage).
module pw_channel
   import pw_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             start,
   input  logic             oneshot,
   input  logic             in_bit,
   input  logic             grant,
   output logic             pending,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             ovf
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(sat_max(WIDTH));
   logic             prev;
   logic             trk;
   logic [WIDTH-1:0] cnt;
   logic             comp;
   logic             rise;
   assign comp = run && trk && !in_bit;
   // prev runs in every state so an input already high at arm never looks like a rise
   assign rise = run && !trk && in_bit && !prev && !(oneshot && done);
   always_ff @(posedge clk) begin
      if (rst) begin
         prev    <= 1'b0;
         trk     <= 1'b0;
         cnt     <= '0;
         result  <= '0;
         pending <= 1'b0;
         done    <= 1'b0;
      end else begin
         prev <= in_bit;
         if (start) done <= 1'b0;
         if (grant) pending <= 1'b0;
         if (!run) begin
            trk <= 1'b0;
            cnt <= '0;
         end else if (comp) begin
            trk  <= 1'b0;
            cnt  <= '0;
            done <= 1'b1;
            // an unclaimed older result wins; the new one is dropped
            if (!pending || grant) begin
               result  <= cnt;
               pending <= 1'b1;
            end
         end else if (trk) begin
            cnt <= (cnt == MAX) ? cnt : cnt + 1'b1;
         end else if (rise) begin
            trk <= 1'b1;
            cnt <= WIDTH'(1);
         end
      end
   end
`ifdef PW_ARB_OVF_EN
   always_ff @(posedge clk) begin
      if (rst || start) ovf <= 1'b0;
      else if (comp && pending && !grant) ovf <= 1'b1;
      else if (grant) ovf <= 1'b0;
   end
`else
   assign ovf = 1'b0;
`endif
endmodule

// File: rtl/pw_capture_arbiter.sv
// pw_capture_arbiter: multi-channel pulse-width capture with arm/run/drain session
// control and a round-robin valid/ready result stream.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   arm      - pulse; starts a session from IDLE
//   oneshot  - sampled with arm; 1 = one result per channel then stop
//   stop     - pulse; ends a continuous session (RUN -> DRAIN)
//   in_data  - probe inputs, one bit per channel
//   busy     - session active (state != IDLE)
//   res      - result stream (master side of pw_capture_arbiter_if)
// Optional feature macro: PW_ARB_OVF_EN (out_ovf reports dropped results;
// without it out_ovf is constant 0).
module pw_capture_arbiter
   import pw_arb_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           arm,
   input  logic           oneshot,
   input  logic           stop,
   input  logic [NCH-1:0] in_data,
   output logic           busy,
   pw_capture_arbiter_if.master res
);
   localparam int CHW = chw(NCH);
   state_t           state;
   state_t           state_nx;
   logic             mode;
   logic             run;
   logic             start;
   logic             load;
   logic             any;
   logic [CHW-1:0]   ptr;
   logic [CHW-1:0]   gnt;
   logic [CHW-1:0]   idx [NCH];
   logic [NCH-1:0]   pend;
   logic [NCH-1:0]   done;
   logic [NCH-1:0]   lovf;
   logic [NCH-1:0]   grant;
   logic [WIDTH-1:0] result [NCH];
   logic             valid_q;
   logic             ovf_q;
   logic [WIDTH-1:0] data_q;
   logic [CHW-1:0]   ch_q;
   genvar i;
   generate
      for (i = 0; i < NCH; i++) begin : g_lane
         pw_channel #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .run    (run),
            .start  (start),
            .oneshot(mode),
            .in_bit (in_data[i]),
            .grant  (grant[i]),
            .pending(pend[i]),
            .result (result[i]),
            .done   (done[i]),
            .ovf    (lovf[i])
         );
      end
   endgenerate
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mode  <= 1'b0;
      end else begin
         state <= state_nx;
         if (start) mode <= oneshot;
      end
   end
   always_comb
      state_nx = (state == IDLE) ? (arm ? RUN : IDLE) :
                 (state == RUN)  ? (((stop && !mode) || (mode && &done)) ? DRAIN : RUN) :
                 (!(|pend) && load) ? IDLE : DRAIN;
   always_comb begin
      busy  = (state != IDLE);
      run   = (state == RUN);
      start = (state == IDLE) && arm;
   end
   // search order starts at the round-robin pointer and wraps
   always_comb
      for (int k = 0; k < NCH; k++) idx[k] = CHW'((int'(ptr) + k) % NCH);
   // walking from the far end lets the nearest pending lane overwrite the rest
   always_comb begin
      any = 1'b0;
      gnt = '0;
      for (int k = NCH - 1; k >= 0; k--)
         if (pend[idx[k]]) begin
            any = 1'b1;
            gnt = idx[k];
         end
   end
   assign load  = !valid_q || res.out_ready;
   assign grant = (load && any) ? (NCH'(1) << gnt) : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
         ovf_q   <= 1'b0;
         ptr     <= '0;
      end else if (load) begin
         valid_q <= any;
         if (any) begin
            data_q <= result[gnt];
            ch_q   <= gnt;
            ovf_q  <= lovf[gnt];
            ptr    <= (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
         end
      end
   end
   assign res.out_valid = valid_q;
   assign res.out_data  = data_q;
   assign res.out_ch    = ch_q;
   assign res.out_ovf   = ovf_q;
endmodule

// File: tb/tb_pw_capture_arbiter.sv
// tb_pw_capture_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the capture/arbitration rules.
module tb_pw_capture_arbiter;
   localparam int NCH   = 4;
   localparam int WIDTH = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef PW_ARB_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           arm = 1'b0;
   logic           oneshot = 1'b0;
   logic           stop = 1'b0;
   logic           busy;
   logic [NCH-1:0] in_data = '0;
   int checks = 0;
   int errors = 0;
   int m_st, m_ptr, m_d, m_c;
   bit m_mode, m_v, m_o;
   int m_len [NCH];
   int m_res [NCH];
   bit m_trk [NCH];
   bit m_prev [NCH];
   bit m_pend [NCH];
   bit m_done [NCH];
   bit m_ovf [NCH];
   int acc_ch [$];
   int acc_d [$];
   pw_capture_arbiter_if #(.NCH(NCH), .WIDTH(WIDTH)) res_if();
   pw_capture_arbiter #(.NCH(NCH), .WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .arm    (arm),
      .oneshot(oneshot),
      .stop   (stop),
      .in_data(in_data),
      .busy   (busy),
      .res    (res_if)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   // Reference: pulse lengths kept as unbounded integers and saturated only when a word is emitted
   task automatic model_step();
      bit load, alldone, anypend, gi;
      bit ppre [NCH];
      int g, id;
      if (rst) begin
         m_st = 0; m_mode = 0; m_ptr = 0; m_v = 0; m_d = 0; m_c = 0; m_o = 0;
         for (int i = 0; i < NCH; i++) begin
            m_len[i] = 0; m_res[i] = 0; m_trk[i] = 0; m_prev[i] = 0;
            m_pend[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
         end
         return;
      end
      load = !m_v || (res_if.out_ready === 1'b1);
      g = -1; alldone = 1; anypend = 0;
      for (int k = 0; k < NCH; k++) begin
         id = (m_ptr + k) % NCH;
         if (g < 0 && m_pend[id]) g = id;
         ppre[k] = m_pend[k];
         alldone &= m_done[k];
         anypend |= m_pend[k];
      end
      if (load) begin
         m_v = (g >= 0);
         if (g >= 0) begin
            m_d = (m_res[g] > MAXV) ? MAXV : m_res[g];
            m_c = g;
            m_o = OVF_EN && m_ovf[g];
            m_ovf[g] = 0;
            m_pend[g] = 0;
            m_ptr = (g + 1) % NCH;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         gi = load && (g == i);
         if (m_st == 1) begin
            if (m_trk[i]) begin
               if (in_data[i]) m_len[i]++;
               else begin
                  m_trk[i] = 0;
                  m_done[i] = 1;
                  if (!ppre[i] || gi) begin
                     m_res[i] = m_len[i];
                     m_pend[i] = 1;
                  end else m_ovf[i] = 1;
                  m_len[i] = 0;
               end
            end else if (in_data[i] && !m_prev[i] && !(m_mode && m_done[i])) begin
               m_trk[i] = 1;
               m_len[i] = 1;
            end
         end else begin
            m_trk[i] = 0;
            m_len[i] = 0;
         end
         m_prev[i] = in_data[i];
      end
      case (m_st)
         0: if (arm) begin
            m_st = 1;
            m_mode = oneshot;
            for (int i = 0; i < NCH; i++) begin
               m_done[i] = 0;
               m_ovf[i] = 0;
            end
         end
         1: if ((stop && !m_mode) || (m_mode && alldone)) m_st = 2;
         default: if (!anypend && load) m_st = 0;
      endcase
   endtask
   task automatic compare();
      chk("busy", busy, 32'(m_st != 0));
      chk("out_valid", res_if.out_valid, 32'(m_v));
      if (m_v) begin
         chk("out_data", res_if.out_data, m_d);
         chk("out_ch", res_if.out_ch, m_c);
         chk("out_ovf", res_if.out_ovf, 32'(m_o));
      end
   endtask
   task automatic tick();
      if (res_if.out_valid === 1'b1 && res_if.out_ready === 1'b1) begin
         acc_ch.push_back(int'(res_if.out_ch));
         acc_d.push_back(int'(res_if.out_data));
      end
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask
   task automatic drive(input logic [NCH-1:0] v, input int n);
      in_data = v;
      repeat (n) tick();
   endtask
   task automatic restart(input logic os);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      arm = 1'b1;
      oneshot = os;
      tick();
      arm = 1'b0;
      acc_ch.delete();
      acc_d.delete();
   endtask
   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         tick();
         n++;
      end
      chk("idle_wait", busy, 0);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, res_if.out_valid, 0);
      chk({tag, "_data"}, res_if.out_data, 0);
      chk({tag, "_ch"}, res_if.out_ch, 0);
      chk({tag, "_ovf"}, res_if.out_ovf, 0);
   endtask
   initial begin
      int n0, d0;
      res_if.out_ready = 1'b1;
      tick();
      tick();
      chk_zero("rst");
      restart(1'b0);
      chk("arm_busy", busy, 1);
      drive(4'b0001, 5);
      drive(4'b0000, 1);
      chk("t1_latency", res_if.out_valid, 0);
      tick();
      chk("t1_valid", res_if.out_valid, 1);
      chk("t1_data", res_if.out_data, 5);
      chk("t1_ch", res_if.out_ch, 0);
      chk("t1_ovf", res_if.out_ovf, 0);
      drive(4'b0010, 300);
      drive(4'b0000, 2);
      chk("t2_valid", res_if.out_valid, 1);
      chk("t2_sat", res_if.out_data, 255);
      chk("t2_ch", res_if.out_ch, 1);
      restart(1'b0);
      drive(4'b1111, 3);
      drive(4'b0000, 1);
      for (int i = 0; i < NCH; i++) begin
         tick();
         chk("t3_valid", res_if.out_valid, 1);
         chk("t3_order", res_if.out_ch, i);
      end
      restart(1'b0);
      res_if.out_ready = 1'b0;
      drive(4'b0001, 2);
      drive(4'b0000, 2);
      drive(4'b0100, 3);
      drive(4'b0000, 2);
      drive(4'b0100, 7);
      drive(4'b0000, 2);
      chk("t4_hold_ch", res_if.out_ch, 0);
      chk("t4_hold_data", res_if.out_data, 2);
      res_if.out_ready = 1'b1;
      tick();
      chk("t4_valid", res_if.out_valid, 1);
      chk("t4_data", res_if.out_data, 3);
      chk("t4_ch", res_if.out_ch, 2);
      chk("t4_ovf", res_if.out_ovf, 32'(OVF_EN));
      tick();
      chk("t4_dropped", res_if.out_valid, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle(50);
      in_data = 4'b0001;
      restart(1'b1);
      drive(4'b0001, 2);
      drive(4'b0000, 2);
      drive(4'b0001, 4);
      drive(4'b0000, 2);
      drive(4'b0001, 6);
      drive(4'b0000, 2);
      drive(4'b1110, 2);
      drive(4'b0000, 1);
      wait_idle(100);
      n0 = 0;
      d0 = -1;
      foreach (acc_ch[k]) if (acc_ch[k] == 0) begin
         n0++;
         d0 = acc_d[k];
      end
      chk("t5_words", acc_d.size(), 4);
      chk("t5_ch0_count", n0, 1);
      chk("t5_ch0_data", d0, 4);
      restart(1'b0);
      drive(4'b1000, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("t6");
      arm = 1'b1;
      tick();
      arm = 1'b0;
      drive(4'b0000, 10);
      chk("t6_no_stale", res_if.out_valid, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle(50);
      for (int c = 0; c < 4000; c++) begin
         arm = ($urandom_range(0, 15) == 0);
         oneshot = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 1999) == 0);
         res_if.out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NCH; i++) if ($urandom_range(0, 5) == 0) in_data[i] = ~in_data[i];
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
